// File: rtl/alu_issue.sv
// RV32I decode-and-issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU op + operands behind a two-entry skid buffer.
// Optional illegal-instruction drain counter enabled by defining ALU_ISSUE_ILLEGAL_CNT_EN.
module alu_issue #(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [31:0]       inst,
  input  logic [N_BITS-1:0] pc,
  input  logic [N_BITS-1:0] rs1_data,
  input  logic [N_BITS-1:0] rs2_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        ex_alu_op,
  output logic [N_BITS-1:0] ex_in0,
  output logic [N_BITS-1:0] ex_in1,
  output logic [4:0]        ex_rd,
  output logic              ex_illegal
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  ,
  output logic [15:0]       illegal_cnt
`endif
);

  typedef struct packed {
    logic              illegal;
    logic [3:0]        op;
    logic [N_BITS-1:0] in0;
    logic [N_BITS-1:0] in1;
    logic [4:0]        rd;
  } entry_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       is_shift;
  entry_t     dec;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Register numbers for rs1/rs2 are resolved upstream; only the data arrives here.
  logic unused_rs1_field;
  assign unused_rs1_field = ^inst[19:15];

  always_comb begin
    dec      = '0;
    dec.rd   = inst[11:7];
    legal    = 1'b0;
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.op  = {funct3, ((funct3 == 3'b000) || (funct3 == 3'b101)) ? funct7[5] : 1'b0};
        dec.in0 = rs1_data;
        dec.in1 = rs2_data;
      end
      OPC_OPIMM: begin
        legal = !(is_shift && (funct7 != 7'b0000000) && (funct7 != 7'b0100000)) &&
                !((funct3 == 3'b001) && inst[30]);
        // Only SRLI/SRAI take bit 30 as the op modifier; ADDI with bit 30 set stays ADD.
        dec.op  = {funct3, (funct3 == 3'b101) ? inst[30] : 1'b0};
        dec.in0 = rs1_data;
        dec.in1 = is_shift ? {{(N_BITS-5){1'b0}}, inst[24:20]}
                           : {{(N_BITS-12){inst[31]}}, inst[31:20]};
      end
      OPC_LUI: begin
        legal   = 1'b1;
        dec.op  = 4'b0000;
        dec.in0 = '0;
        dec.in1 = {inst[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        dec.op  = 4'b0000;
        dec.in0 = pc;
        dec.in1 = {inst[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.op  = 4'b0000;
      dec.in0 = '0;
      dec.in1 = '0;
    end
    dec.illegal = !legal;
  end

  entry_t main_reg, main_next, skid_reg, skid_next;
  logic   main_valid_reg, main_valid_next;
  logic   skid_valid_reg, skid_valid_next;
  logic   ready_reg;
  logic   accept, drain;

  assign accept = inst_valid & ready_reg & ~flush;
  assign drain  = main_valid_reg & ex_ready & ~flush;

  always_comb begin
    main_next       = main_reg;
    main_valid_next = main_valid_reg;
    skid_next       = skid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (drain) begin
      // inst_ready is low whenever skid is occupied, so accept and skid refill never coincide.
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_next = dec;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_reg) begin
        main_next       = dec;
        main_valid_next = 1'b1;
      end else begin
        skid_next       = dec;
        skid_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ~skid_valid_next;
    end
  end

  assign inst_ready = ready_reg;
  assign ex_valid   = main_valid_reg;
  assign ex_alu_op  = main_reg.op;
  assign ex_in0     = main_reg.in0;
  assign ex_in1     = main_reg.in1;
  assign ex_rd      = main_reg.rd;
  assign ex_illegal = main_reg.illegal;

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt_reg <= '0;
    end else if (drain && main_reg.illegal && (illegal_cnt_reg != 16'hFFFF)) begin
      illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
    end
  end

  assign illegal_cnt = illegal_cnt_reg;
`else
  // Counter absent: illegal entries are still flagged on ex_illegal.
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed table-driven bench for alu_issue: decode vectors, skid buffer, flush and reset sequences.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n, flush, inst_valid, inst_ready;
  logic [31:0] inst, pc, rs1_data, rs2_data;
  logic        ex_valid, ex_ready, ex_illegal;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_in0, ex_in1;
  logic [4:0]  ex_rd;
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;
`endif

  always #5 clk = ~clk;

  alu_issue #(.N_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
    .ex_in0(ex_in0), .ex_in1(ex_in1), .ex_rd(ex_rd), .ex_illegal(ex_illegal)
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    , .illegal_cnt(illegal_cnt)
`endif
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  localparam int NV = 15;
  localparam logic [31:0] ADD_X3 = 32'h002081B3;
  vec_t vecs [NV];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b);
    inst = i; pc = p; rs1_data = a; rs2_data = b; inst_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; inst_valid = 1'b0; ex_ready = 1'b0;
    inst = '0; pc = '0; rs1_data = '0; rs2_data = '0;

    //            inst          pc            rs1           rs2           op       in0           in1           rd  ill
    vecs[0]  = '{32'h403100B3, 32'h0,        32'd10,       32'd3,        4'b0001, 32'd10,       32'd3,        5'd1, 1'b0};
    vecs[1]  = '{32'h40735293, 32'h0,        32'h80000000, 32'h0,        4'b1011, 32'h80000000, 32'd7,        5'd5, 1'b0};
    vecs[2]  = '{32'h123450B7, 32'h0,        32'h11,       32'h22,       4'b0000, 32'h0,        32'h12345000, 5'd1, 1'b0};
    vecs[3]  = '{32'hFFF00093, 32'h0,        32'h55,       32'h0,        4'b0000, 32'h55,       32'hFFFFFFFF, 5'd1, 1'b0};
    vecs[4]  = '{32'h0000007F, 32'h0,        32'h33,       32'h44,       4'b0000, 32'h0,        32'h0,        5'd0, 1'b1};
    vecs[5]  = '{32'hABCDE117, 32'h1000,     32'h9,        32'h0,        4'b0000, 32'h1000,     32'hABCDE000, 5'd2, 1'b0};
    vecs[6]  = '{32'h002081B3, 32'h0,        32'h7,        32'h8,        4'b0000, 32'h7,        32'h8,        5'd3, 1'b0};
    vecs[7]  = '{32'h4062D233, 32'h0,        32'hF0000000, 32'h4,        4'b1011, 32'hF0000000, 32'h4,        5'd4, 1'b0};
    vecs[8]  = '{32'h0020B3B3, 32'h0,        32'h1,        32'h2,        4'b0110, 32'h1,        32'h2,        5'd7, 1'b0};
    vecs[9]  = '{32'h4020F1B3, 32'h0,        32'h1,        32'h2,        4'b0000, 32'h0,        32'h0,        5'd3, 1'b1};
    vecs[10] = '{32'h40109093, 32'h0,        32'h1,        32'h2,        4'b0000, 32'h0,        32'h0,        5'd1, 1'b1};
    vecs[11] = '{32'hFFB12093, 32'h0,        32'h6,        32'h0,        4'b0100, 32'h6,        32'hFFFFFFFB, 5'd1, 1'b0};
    vecs[12] = '{32'h7FF0F093, 32'h0,        32'hFF,       32'h0,        4'b1110, 32'hFF,       32'h7FF,      5'd1, 1'b0};
    vecs[13] = '{32'h0210D093, 32'h0,        32'h1,        32'h0,        4'b0000, 32'h0,        32'h0,        5'd1, 1'b1};
    vecs[14] = '{32'h022081B3, 32'h0,        32'h1,        32'h2,        4'b0000, 32'h0,        32'h0,        5'd3, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 80'(ex_valid), 80'(0));
    chk("rst_ready", 80'(inst_ready), 80'(0));
    chk("rst_payload", 80'({ex_illegal, ex_alu_op, ex_rd, ex_in0, ex_in1}), 80'(0));
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 80'(inst_ready), 80'(1));

    // Decode table, one accept per cycle with ex_ready held high
    ex_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      offer(vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      tick();
      inst_valid = 1'b0;
      chk($sformatf("vec%0d_%h", i, vecs[i].inst),
          80'({ex_valid, ex_illegal, ex_alu_op, ex_rd, ex_in0, ex_in1, inst_ready}),
          80'({1'b1, vecs[i].ill, vecs[i].op, vecs[i].rd, vecs[i].in0, vecs[i].in1, 1'b1}));
    end
    tick();
    chk("table_drained", 80'(ex_valid), 80'(0));
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    chk("illegal_cnt_table", 80'(illegal_cnt), 80'(5));
`endif

    // Skid: three back-to-back offers with ex_ready low, then drain in order
    ex_ready = 1'b0;
    offer(ADD_X3, 0, 32'hA1, 1);
    tick();
    chk("skid_a_in", 80'({ex_valid, inst_ready, ex_in0}), 80'({1'b1, 1'b1, 32'hA1}));
    offer(ADD_X3, 0, 32'hB2, 1);
    tick();
    chk("skid_b_in", 80'({ex_valid, inst_ready, ex_in0}), 80'({1'b1, 1'b0, 32'hA1}));
    offer(ADD_X3, 0, 32'hC3, 1);
    tick();
    chk("skid_c_held", 80'({ex_valid, inst_ready, ex_in0}), 80'({1'b1, 1'b0, 32'hA1}));
    ex_ready = 1'b1;
    tick();
    chk("drain_a", 80'({ex_valid, inst_ready, ex_in0}), 80'({1'b1, 1'b1, 32'hB2}));
    tick();
    inst_valid = 1'b0;
    chk("drain_b", 80'({ex_valid, inst_ready, ex_in0}), 80'({1'b1, 1'b1, 32'hC3}));
    tick();
    chk("drain_c", 80'({ex_valid, inst_ready}), 80'({1'b0, 1'b1}));

    // Flush a full buffer holding an illegal entry
    ex_ready = 1'b0;
    offer(32'h0000007F, 0, 32'hD1, 1);
    tick();
    offer(ADD_X3, 0, 32'hD2, 1);
    tick();
    inst_valid = 1'b0;
    chk("full_ready", 80'({ex_valid, inst_ready}), 80'({1'b1, 1'b0}));
    flush = 1'b1;
    ex_ready = 1'b1;
    tick();
    flush = 1'b0;
    ex_ready = 1'b0;
    chk("flush_state", 80'({ex_valid, inst_ready}), 80'({1'b0, 1'b1}));
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    chk("illegal_cnt_flush", 80'(illegal_cnt), 80'(5));
`endif

    // Reset mid-stream with an entry pending
    offer(ADD_X3, 0, 32'hE1, 32'hE2);
    tick();
    inst_valid = 1'b0;
    chk("pre_rst_valid", 80'({ex_valid, ex_in1}), 80'({1'b1, 32'hE2}));
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("mid_rst", 80'({ex_valid, inst_ready, ex_illegal, ex_alu_op, ex_rd, ex_in0, ex_in1}), 80'(0));
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    chk("illegal_cnt_rst", 80'(illegal_cnt), 80'(0));
`endif
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst2", 80'({ex_valid, inst_ready}), 80'({1'b0, 1'b1}));

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    // Saturation: stream 70000 illegal instructions through
    ex_ready = 1'b1;
    offer(32'h0000007F, 0, 0, 0);
    tick();
    chk("illegal_cnt_first", 80'(illegal_cnt), 80'(0));
    tick();
    chk("illegal_cnt_one", 80'(illegal_cnt), 80'(1));
    repeat (70000) @(posedge clk);
    #1;
    inst_valid = 1'b0;
    tick();
    chk("illegal_cnt_sat", 80'(illegal_cnt), 80'(16'hFFFF));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage feeding the RV32I ALU. Accepts one instruction word per cycle with its PC and register-file read data, decodes OP, OP-IMM, LUI and AUIPC into the 4-bit ALU operation code and the two ALU operands, and presents them to the execute stage. A two-entry skid buffer sits between the two ports so that `inst_ready` is a registered signal. It sits between register read and the ALU.

## Interface
- `N_BITS`, 32, datapath width; only 32 is supported.
- `clk` in 1, sole clock; all state updates on the rising edge.
- `rst_n` in 1, synchronous, active-low reset.
- `flush` in 1, synchronous kill of all buffered entries.
- `inst_valid` in 1, upstream offers an instruction.
- `inst_ready` out 1, stage can accept; registered.
- `inst` in 32, RV32I instruction word.
- `pc` in N_BITS, PC of `inst`.
- `rs1_data` in N_BITS, rs1 read value.
- `rs2_data` in N_BITS, rs2 read value.
- `ex_valid` out 1, decoded entry is available.
- `ex_ready` in 1, execute stage accepts.
- `ex_alu_op` out 4, ALU operation code.
- `ex_in0` out N_BITS, ALU operand 0.
- `ex_in1` out N_BITS, ALU operand 1.
- `ex_rd` out 5, destination register.
- `ex_illegal` out 1, instruction was not decodable by this stage.
- `illegal_cnt` out 16, illegal-instruction counter; present only with `ALU_ISSUE_ILLEGAL_CNT_EN`.

## Operation
**ALU op codes**
- ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
- The general rule is `alu_op = {funct3, b0}`.
- For OP, `b0 = funct7[5]`, and only when funct3 is 000 or 101; otherwise `b0 = 0`.
- For OP-IMM, `b0 = inst[30]`, and only when funct3 is 101. ADDI never produces SUB.

**Operands**
- OP (0110011): in0 = rs1_data, in1 = rs2_data.
- OP-IMM (0010011): in0 = rs1_data, in1 = sign-extended I-immediate. For shifts, in1 = zero-extended `inst[24:20]`.
- LUI (0110111): in0 = 0, in1 = `{inst[31:12], 12'b0}`, op ADD.
- AUIPC (0010111): in0 = pc, in1 = U-immediate, op ADD.

**Illegal instructions**
- Illegal means any of:
  - any other opcode;
  - OP with funct7 not equal to 0000000 and not equal to 0100000;
  - OP with funct7 = 0100000 and funct3 not 000 or 101;
  - OP-IMM shift with `inst[31:25]` not equal to 0000000 and not equal to 0100000;
  - OP-IMM with funct3 = 001 and `inst[30]` = 1.
- An illegal entry is still issued, with `ex_illegal` = 1, op 0000, in0 = in1 = 0, and rd = `inst[11:7]`.

**Skid buffer**
- The buffer has a main entry (drives the `ex_*` outputs) and a skid entry.
- Transfer in occurs when `inst_valid & inst_ready`; transfer out occurs when `ex_valid & ex_ready`.
- `inst_ready` equals the registered value of "skid entry empty".
- On accept:
  - if main is empty, or is draining this cycle, the new entry goes to main;
  - otherwise it goes to skid.
- On drain with skid full, skid moves to main. A simultaneous accept cannot occur in that case, because `inst_ready` is 0.
- Once asserted, `ex_valid` and the `ex_*` payload stay stable until `ex_ready` is seen.

## Timing
- Latency: an instruction accepted at edge N is visible on `ex_*` with `ex_valid` = 1 after edge N.
- Throughput: 1 instruction per cycle while `ex_ready` is held at 1.
- Reset, while `rst_n` = 0 at an edge:
  - both entries are cleared;
  - `ex_valid` = 0, `inst_ready` = 0, and all `ex_*` payload = 0;
  - `illegal_cnt` = 0.
- `inst_ready` rises at the first edge with `rst_n` = 1.
- Reset asserted mid-stream discards both entries with no drain.
- `flush` = 1 at an edge clears both entries and blocks that cycle's accept and drain. It does not clear `illegal_cnt`. `inst_ready` = 1 after the edge.
- If `rst_n` = 0 and `flush` = 1 together, reset applies.
- Full buffer (both entries valid): `inst_ready` = 0 until the edge after a drain.

## Configuration
- `ALU_ISSUE_ILLEGAL_CNT_EN` defined:
  - `illegal_cnt` exists;
  - it increments by 1 at each edge where an entry with `ex_illegal` = 1 drains;
  - it saturates at 0xFFFF.
- Not defined: the port and the counter logic are absent. Decode, `ex_illegal` and timing are identical in both builds.

## Test plan
- `inst` = 0x403100B3 (sub x1,x2,x3), rs1_data = 10, rs2_data = 3, `ex_ready` = 1 → next cycle `ex_alu_op` = 0001, `ex_in0` = 10, `ex_in1` = 3, `ex_rd` = 1, `ex_illegal` = 0.
- `inst` = 0x40735293 (srai x5,x6,7), rs1_data = 0x80000000 → `ex_alu_op` = 1011, `ex_in1` = 7, `ex_rd` = 5.
- `inst` = 0x123450B7 (lui x1) → `ex_alu_op` = 0000, `ex_in0` = 0, `ex_in1` = 0x12345000. `inst` = 0xFFF00093 (addi x1,x0,-1) → `ex_in1` = 0xFFFFFFFF, `ex_alu_op` = 0000.
- `ex_ready` = 0 and 3 back-to-back valid instructions → 2 accepted, `inst_ready` = 0 after the 2nd. Then `ex_ready` = 1 → entries drain in order with no loss or duplication, and `inst_ready` returns to 1 one cycle after the first drain.
- `inst` = 0x0000007F → `ex_illegal` = 1, op 0000, operands 0. With `ALU_ISSUE_ILLEGAL_CNT_EN`, `illegal_cnt` = 1 after the drain; 70000 illegal drains → 0xFFFF.
- Buffer full, then `flush` = 1 for one cycle → `ex_valid` = 0 and `inst_ready` = 1 next cycle. Then `rst_n` = 0 for one cycle → all outputs 0 and `inst_ready` = 0, with `inst_ready` = 1 one edge after release.
